sdram_cache: RTL and testbench
==============================

# sdram_cache

Direct-mapped, write-through, no-write-allocate word cache that sits between the CPU data bus and the SDRAM controller's valid/ready request port. Read hits return data in 2 cycles without touching SDRAM. Read misses fetch one 32-bit word and fill the line. Every write is forwarded to SDRAM, and a write hit also updates the cached word byte-wise.

## Interface
- `IDX_W`, default 8: index width. The cache holds 2^IDX_W 32-bit words.
- `ADDR_W`, default 25: byte-address width, matching the controller's `addr`.
- `clk` in 1: single clock, shared with the SDRAM controller.
- `resetn` in 1: reset is synchronous and active-low.
- `cpu_valid` in 1: request strobe. Held until `cpu_ready`.
- `cpu_addr` in `ADDR_W`: byte address. Bits [1:0] are ignored.
- `cpu_wmask` in 4: byte enables. Nonzero means write; zero means read.
- `cpu_din` in 32: write data.
- `cpu_dout` out 32: read data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_valid` out 1: request to the controller.
- `mem_addr` out `ADDR_W`: word-aligned byte address (bits [1:0]=0).
- `mem_din` out 32: write data to the controller.
- `mem_wmask` out 4: 0 for a fill; otherwise `cpu_wmask`.
- `mem_dout` in 32: controller read data, valid with `mem_ready`.
- `mem_ready` in 1: controller completion pulse.

## Operation
- Address split: index = `cpu_addr[IDX_W+1:2]`; tag = `cpu_addr[ADDR_W-1:IDX_W+2]` (TAG_W = ADDR_W-2-IDX_W bits).
- Storage:
  - Per-line valid bits are held in flops and cleared by reset.
  - Tag and data are held in synchronous-read RAMs.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, DONE.
- IDLE:
  - If `cpu_valid`=1 and `cpu_ready`=0, latch addr/wmask/din, present the index to both RAMs, and go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP: hit = valid[idx] and (tag_ram == tag).
  - Read hit: `cpu_dout` <= data_ram, go to DONE.
  - Read miss: drive `mem_valid`=1, `mem_wmask`=0, `mem_addr`={addr[ADDR_W-1:2],2'b00}, go to MEM_RD.
  - Write (hit or miss): drive `mem_valid`=1, `mem_wmask`=`cpu_wmask`, `mem_din`=`cpu_din`, go to MEM_WR.
  - On a write hit, merge the enabled bytes of `cpu_din` into data_ram[idx] on this edge.
  - On a write miss, leave the cache unchanged.
- MEM_RD: on `mem_ready`=1:
  - Clear `mem_valid`.
  - Write `mem_dout` to data_ram and tag to tag_ram, and set valid[idx].
  - `cpu_dout` <= `mem_dout`; go to DONE.
- MEM_WR: on `mem_ready`=1, clear `mem_valid` and go to DONE.
- DONE: `cpu_ready`=1 for exactly one cycle, then IDLE. A `cpu_valid` still high in that cycle is not a new request.
- `mem_valid` must be low in the cycle after `mem_ready`. The controller re-arms on valid && !ready.
- Reset values:
  - `cpu_ready`=0, `cpu_dout`=0.
  - `mem_valid`=0, `mem_addr`=0, `mem_din`=0, `mem_wmask`=0.
  - All valid bits 0, state IDLE.
- Reset mid-transaction abandons the request. The controller shares `resetn` and restarts its own init.

## Timing
- Request accepted at edge N (IDLE, `cpu_valid`=1). LOOKUP occupies cycle N+1.
- Read hit: `cpu_ready`=1 in cycle N+2.
- Miss or write: `mem_valid`=1 from cycle N+2 through cycle M, where `mem_ready`=1 in cycle M. `cpu_ready`=1 in cycle M+1.
- The earliest next acceptance is the cycle after `cpu_ready`.
- Memory outputs (`mem_addr`, `mem_din`, `mem_wmask`) are stable while `mem_valid`=1.
- Fill and write-hit updates to the RAMs are visible to a request accepted in the cycle after `cpu_ready`.

## Structure
- Package `sdram_cache_pkg`: state enum, the TAG_W computation, and the byte-merge function.
- One sub-module, `sdram_cache_ram` (parameterised width/depth, single port, synchronous read, write-first). It is instantiated twice: once for tags and once for data.

## Test plan
- After reset, read 0x0000100: miss, `mem_valid` with `mem_wmask`=0. Model returns 0xDEADBEEF. `cpu_dout`=0xDEADBEEF. Re-reading 0x0000100 hits in 2 cycles with no `mem_valid`.
- Write 0x0000100, wmask=4'b0011, din=0x12345678: one SDRAM write with mask 0011. A subsequent read hits and returns 0xDEAD5678.
- Alias: read 0x0000100, then 0x0000500 (same index, IDX_W=8), then 0x0000100: three misses. Each returns the model's value for its own address.
- Write miss to 0x0000200: SDRAM write issued. The following read of 0x0000200 misses; no allocation occurred.
- Model holds `mem_ready` off for 50 cycles: `mem_valid` and address stay stable throughout. `mem_valid` is low the cycle after `mem_ready`. `cpu_ready` is a single pulse.
- `resetn` asserted during MEM_RD: all outputs return to 0. After release, a previously cached address misses.

Source files
------------

// File: rtl/sdram_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through SDRAM word cache.
package sdram_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRd,
    StMemWr,
    StDone
  } state_e;

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned idx_w);
    return addr_w - 2 - idx_w;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// Single-port synchronous-read RAM; a write returns the new word on the same edge.
module sdram_cache_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256
) (
  input  logic                     clk_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic                     we_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of the SDRAM controller.
module sdram_cache
  import sdram_cache_pkg::*;
#(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              cpu_valid_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [3:0]        cpu_wmask_i,
  input  logic [31:0]       cpu_din_i,
  output logic [31:0]       cpu_dout_o,
  output logic              cpu_ready_o,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [31:0]       mem_dout_i,
  input  logic              mem_ready_i
);

  localparam int unsigned TagW  = tag_width(ADDR_W, IDX_W);
  localparam int unsigned Depth = 1 << IDX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   waddr_q, waddr_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         cpu_dout_q, cpu_dout_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic [3:0]          mem_wmask_q, mem_wmask_d;
  logic [Depth-1:0]    valid_q, valid_d;

  logic [IDX_W-1:0]    idx_q;
  logic [TagW-1:0]     tag_q;
  logic [IDX_W-1:0]    ram_idx;
  logic                tag_we, data_we;
  logic [31:0]         data_wdata;
  logic [TagW-1:0]     tag_rdata;
  logic [31:0]         data_rdata;
  logic                hit;
  logic                unused_addr_lo;

  // Byte offset never matters: the cache and the controller are word-granular.
  assign unused_addr_lo = ^cpu_addr_i[1:0];

  assign idx_q = waddr_q[IDX_W+1:2];
  assign tag_q = waddr_q[ADDR_W-1:IDX_W+2];
  assign hit   = valid_q[idx_q] && (tag_rdata == tag_q);

  sdram_cache_ram #(
    .Width (TagW),
    .Depth (Depth)
  ) u_tag_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_idx),
    .we_i    (tag_we),
    .wdata_i (tag_q),
    .rdata_o (tag_rdata)
  );

  sdram_cache_ram #(
    .Width (32),
    .Depth (Depth)
  ) u_data_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_idx),
    .we_i    (data_we),
    .wdata_i (data_wdata),
    .rdata_o (data_rdata)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wmask_d     = wmask_q;
    din_d       = din_q;
    cpu_dout_d  = cpu_dout_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wmask_d = mem_wmask_q;
    valid_d     = valid_q;
    ram_idx     = idx_q;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    data_wdata  = mem_dout_i;

    unique case (state_q)
      StIdle: begin
        // Present the incoming index so tag/data are ready in LOOKUP.
        ram_idx = cpu_addr_i[IDX_W+1:2];
        if (cpu_valid_i && !cpu_ready_o) begin
          waddr_d = cpu_addr_i[ADDR_W-1:2];
          wmask_d = cpu_wmask_i;
          din_d   = cpu_din_i;
          state_d = StLookup;
        end
      end
      StLookup: begin
        mem_addr_d = {waddr_q, 2'b00};
        if (wmask_q == 4'b0000) begin
          if (hit) begin
            cpu_dout_d = data_rdata;
            state_d    = StDone;
          end else begin
            mem_wmask_d = 4'b0000;
            state_d     = StMemRd;
          end
        end else begin
          mem_wmask_d = wmask_q;
          mem_din_d   = din_q;
          state_d     = StMemWr;
          if (hit) begin
            data_we    = 1'b1;
            data_wdata = merge_bytes(data_rdata, din_q, wmask_q);
          end
        end
      end
      StMemRd: begin
        if (mem_ready_i) begin
          data_we        = 1'b1;
          tag_we         = 1'b1;
          valid_d[idx_q] = 1'b1;
          cpu_dout_d     = mem_dout_i;
          state_d        = StDone;
        end
      end
      StMemWr: begin
        if (mem_ready_i) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      wmask_q     <= '0;
      din_q       <= '0;
      cpu_dout_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wmask_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wmask_q     <= wmask_d;
      din_q       <= din_d;
      cpu_dout_q  <= cpu_dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wmask_q <= mem_wmask_d;
      valid_q     <= valid_d;
    end
  end

  assign cpu_ready_o = (state_q == StDone);
  assign mem_valid_o = (state_q == StMemRd) || (state_q == StMemWr);
  assign cpu_dout_o  = cpu_dout_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_din_o   = mem_din_q;
  assign mem_wmask_o = mem_wmask_q;

endmodule

// File: tb/tb_sdram_cache.sv
// Directed bench for sdram_cache with a behavioural SDRAM controller model.
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [24:0] cpu_addr;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout_o;
  logic        cpu_ready_o;
  logic        mem_valid_o;
  logic [24:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_dout;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Controller model state and observations
  logic [31:0] mmem [logic [24:0]];
  int          mem_delay = 0;
  int          wait_cnt, n_rd, n_wr, vcycles, unstable, valid_after_ready;
  logic        prev_v;
  logic [24:0] cap_addr, last_addr;
  logic [31:0] cap_din, last_din;
  logic [3:0]  cap_mask, last_wmask;

  always #5 clk = ~clk;

  sdram_cache #(
    .IDX_W  (8),
    .ADDR_W (25)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .cpu_valid_i (cpu_valid),
    .cpu_addr_i  (cpu_addr),
    .cpu_wmask_i (cpu_wmask),
    .cpu_din_i   (cpu_din),
    .cpu_dout_o  (cpu_dout_o),
    .cpu_ready_o (cpu_ready_o),
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_din_o   (mem_din_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_dout_i  (mem_dout),
    .mem_ready_i (mem_ready)
  );

  function automatic logic [31:0] rd_word(input logic [24:0] a);
    if (mmem.exists(a)) return mmem[a];
    return 32'hA500_0000 | {7'd0, a};
  endfunction

  initial begin
    mem_ready = 1'b0; mem_dout = '0; wait_cnt = 0; prev_v = 1'b0;
    n_rd = 0; n_wr = 0; vcycles = 0; unstable = 0; valid_after_ready = 0;
    mmem[25'h100] = 32'hDEADBEEF;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        mem_ready = 1'b0; wait_cnt = 0; prev_v = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        if (mem_valid_o) valid_after_ready++;
        prev_v = 1'b0; wait_cnt = 0;
      end else if (mem_valid_o) begin
        if (!prev_v) begin
          cap_addr = mem_addr_o; cap_din = mem_din_o; cap_mask = mem_wmask_o; prev_v = 1'b1;
        end else if (mem_addr_o !== cap_addr || mem_din_o !== cap_din || mem_wmask_o !== cap_mask) begin
          unstable++;
        end
        vcycles++;
        if (wait_cnt < mem_delay) begin
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          last_addr = mem_addr_o; last_din = mem_din_o; last_wmask = mem_wmask_o;
          if (mem_wmask_o == 4'b0000) begin
            n_rd++;
            mem_dout = rd_word(mem_addr_o);
          end else begin
            logic [31:0] w;
            n_wr++;
            w = rd_word(mem_addr_o);
            for (int i = 0; i < 4; i++) if (mem_wmask_o[i]) w[8*i +: 8] = mem_din_o[8*i +: 8];
            mmem[mem_addr_o] = w;
          end
        end
      end
    end
  end

  // Issue one request from an IDLE cycle; returns data and cycles from acceptance edge to ready.
  task automatic do_req(input logic [24:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] dout, output int lat);
    logic got;
    cpu_addr = a; cpu_wmask = m; cpu_din = d; cpu_valid = 1'b1;
    lat = 0; got = 1'b0; dout = 'x;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ready_o) begin
        dout = cpu_dout_o;
        got  = 1'b1;
      end
    end
    cpu_valid = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_timeout addr=%h: no cpu_ready within 300 cycles", a);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cpu_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse addr=%h: cpu_ready=%b, required 0", a, cpu_ready_o);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wmask = '0; cpu_din = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    n_tests += 6;
    if (cpu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu_ready_o); end
    if (cpu_dout_o !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_dout got=%h exp=0", cpu_dout_o); end
    if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid_o); end
    if (mem_addr_o !== 25'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); end
    if (mem_din_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_din got=%h exp=0", mem_din_o); end
    if (mem_wmask_o !== 4'h0) begin n_fail++; $display("FAIL rst_mem_wmask got=%h exp=0", mem_wmask_o); end
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] d; int lat, rd0, vc0;
    rd0 = n_rd;
    do_req(25'h100, 4'b0000, 32'h0, d, lat);
    n_tests += 4;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_data got=%h exp=deadbeef", d); end
    if (n_rd - rd0 !== 1) begin n_fail++; $display("FAIL miss_fill_count got=%0d exp=1", n_rd - rd0); end
    if (last_wmask !== 4'b0000) begin n_fail++; $display("FAIL miss_wmask got=%b exp=0000", last_wmask); end
    if (lat !== 3) begin n_fail++; $display("FAIL miss_latency got=%0d exp=3", lat); end
    rd0 = n_rd; vc0 = vcycles;
    do_req(25'h100, 4'b0000, 32'h0, d, lat);
    n_tests += 3;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data got=%h exp=deadbeef", d); end
    if (lat !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    if (vcycles != vc0 || n_rd != rd0) begin
      n_fail++; $display("FAIL hit_no_mem got=%0d valid cycles exp=0", vcycles - vc0);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] d; int lat, wr0, rd0;
    wr0 = n_wr;
    do_req(25'h102, 4'b0011, 32'h12345678, d, lat);
    n_tests += 5;
    if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL wr_count got=%0d exp=1", n_wr - wr0); end
    if (last_wmask !== 4'b0011) begin n_fail++; $display("FAIL wr_mask got=%b exp=0011", last_wmask); end
    if (last_din !== 32'h12345678) begin n_fail++; $display("FAIL wr_din got=%h exp=12345678", last_din); end
    if (last_addr !== 25'h100) begin n_fail++; $display("FAIL wr_addr_align got=%h exp=100", last_addr); end
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    rd0 = n_rd;
    do_req(25'h100, 4'b0000, 32'h0, d, lat);
    n_tests += 3;
    if (d !== 32'hDEAD5678) begin n_fail++; $display("FAIL wrhit_merge got=%h exp=dead5678", d); end
    if (lat !== 2) begin n_fail++; $display("FAIL wrhit_latency got=%0d exp=2", lat); end
    if (n_rd != rd0) begin n_fail++; $display("FAIL wrhit_no_fill got=%0d exp=0", n_rd - rd0); end
  endtask

  task automatic test_alias();
    logic [31:0] d1, d2, d3; int lat, rd0;
    do_req(25'h900, 4'b0000, 32'h0, d1, lat);
    rd0 = n_rd;
    do_req(25'h100, 4'b0000, 32'h0, d1, lat);
    do_req(25'h500, 4'b0000, 32'h0, d2, lat);
    do_req(25'h100, 4'b0000, 32'h0, d3, lat);
    n_tests += 4;
    if (n_rd - rd0 !== 3) begin n_fail++; $display("FAIL alias_misses got=%0d exp=3", n_rd - rd0); end
    if (d1 !== 32'hDEAD5678) begin n_fail++; $display("FAIL alias_a0 got=%h exp=dead5678", d1); end
    if (d2 !== 32'hA5000500) begin n_fail++; $display("FAIL alias_b got=%h exp=a5000500", d2); end
    if (d3 !== 32'hDEAD5678) begin n_fail++; $display("FAIL alias_a1 got=%h exp=dead5678", d3); end
  endtask

  task automatic test_write_miss();
    logic [31:0] d; int lat, wr0, rd0;
    wr0 = n_wr;
    do_req(25'h200, 4'b1111, 32'hCAFEF00D, d, lat);
    n_tests += 2;
    if (n_wr - wr0 !== 1) begin n_fail++; $display("FAIL wmiss_count got=%0d exp=1", n_wr - wr0); end
    if (last_addr !== 25'h200) begin n_fail++; $display("FAIL wmiss_addr got=%h exp=200", last_addr); end
    rd0 = n_rd;
    do_req(25'h200, 4'b0000, 32'h0, d, lat);
    n_tests += 2;
    if (n_rd - rd0 !== 1) begin n_fail++; $display("FAIL wmiss_no_alloc got=%0d fills exp=1", n_rd - rd0); end
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wmiss_readback got=%h exp=cafef00d", d); end
  endtask

  task automatic test_slow_mem();
    logic [31:0] d; int lat, vc0;
    mem_delay = 50;
    vc0 = vcycles;
    do_req(25'h300, 4'b0000, 32'h0, d, lat);
    n_tests += 3;
    if (lat !== 53) begin n_fail++; $display("FAIL slow_rd_latency got=%0d exp=53", lat); end
    if (vcycles - vc0 !== 51) begin n_fail++; $display("FAIL slow_valid_cycles got=%0d exp=51", vcycles - vc0); end
    if (d !== 32'hA5000300) begin n_fail++; $display("FAIL slow_rd_data got=%h exp=a5000300", d); end
    do_req(25'h304, 4'b1000, 32'h11223344, d, lat);
    n_tests += 4;
    if (lat !== 53) begin n_fail++; $display("FAIL slow_wr_latency got=%0d exp=53", lat); end
    if (last_din !== 32'h11223344) begin n_fail++; $display("FAIL slow_wr_din got=%h exp=11223344", last_din); end
    if (unstable !== 0) begin n_fail++; $display("FAIL slow_stable got=%0d changes exp=0", unstable); end
    if (valid_after_ready !== 0) begin
      n_fail++; $display("FAIL valid_after_ready got=%0d exp=0", valid_after_ready);
    end
    mem_delay = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int lat, rd0;
    mem_delay = 30;
    cpu_addr = 25'h400; cpu_wmask = 4'b0000; cpu_din = 32'h0; cpu_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (mem_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_memrd got=%b exp=1", mem_valid_o); end
    rd0 = n_rd;
    resetn = 1'b0; cpu_valid = 1'b0;
    @(posedge clk); #1;
    n_tests += 6;
    if (cpu_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_ready got=%b exp=0", cpu_ready_o); end
    if (cpu_dout_o !== 32'h0) begin n_fail++; $display("FAIL mid_cpu_dout got=%h exp=0", cpu_dout_o); end
    if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_mem_valid got=%b exp=0", mem_valid_o); end
    if (mem_addr_o !== 25'h0) begin n_fail++; $display("FAIL mid_mem_addr got=%h exp=0", mem_addr_o); end
    if (mem_din_o !== 32'h0) begin n_fail++; $display("FAIL mid_mem_din got=%h exp=0", mem_din_o); end
    if (mem_wmask_o !== 4'h0) begin n_fail++; $display("FAIL mid_mem_wmask got=%h exp=0", mem_wmask_o); end
    @(posedge clk); #1;
    resetn = 1'b1; mem_delay = 0;
    @(posedge clk); #1;
    do_req(25'h200, 4'b0000, 32'h0, d, lat);
    n_tests += 3;
    if (n_rd - rd0 !== 1) begin n_fail++; $display("FAIL mid_invalidate got=%0d fills exp=1", n_rd - rd0); end
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_refetch got=%h exp=cafef00d", d); end
    if (lat !== 3) begin n_fail++; $display("FAIL mid_refetch_latency got=%0d exp=3", lat); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_alias();
    test_write_miss();
    test_slow_mem();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
